// File: rtl/fnn_pkg.sv
// Shared definitions for the fully connected layer datapath: default word width,
// serializer FSM states and a packed-vector word slicer.
package fnn_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam int unsigned MAX_WORDS          = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Word idx of a packed buffer, word 0 in the least significant bits.
    function automatic logic [DEFAULT_DATA_WIDTH-1:0] get_word(
        input logic [MAX_WORDS*DEFAULT_DATA_WIDTH-1:0] buffer,
        input int unsigned                             idx
    );
        return buffer[idx*DEFAULT_DATA_WIDTH +: DEFAULT_DATA_WIDTH];
    endfunction

endpackage

// File: rtl/layer_out_serializer_if.sv
// Parallel neuron outputs of layer L in, serial myinput/myinputValid stream out.
interface layer_out_serializer_if #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16
);
    logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out;
    logic [NUM_NEURONS-1:0]            neuron_valid;
    logic [DATA_WIDTH-1:0]             out_data;
    logic                              out_valid;

    modport slave (
        input  neuron_out,
        input  neuron_valid,
        output out_data,
        output out_valid
    );

    modport master (
        output neuron_out,
        output neuron_valid,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/layer_out_serializer.sv
// Captures one frame of neuron outputs and streams it one word per cycle to the
// next layer, with back-to-back frame acceptance and sticky error flags.
module layer_out_serializer
    import fnn_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH   = $clog2(NUM_NEURONS)
) (
    input  logic                  clk,
    input  logic                  rst,
    layer_out_serializer_if.slave bus,
    input  logic                  clr_err,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_overrun,
    output logic                  err_partial
);

    localparam int                   BUF_BITS = NUM_NEURONS * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_NEURONS - 1);
    localparam bit USE_PKG_SLICE = (DATA_WIDTH == int'(DEFAULT_DATA_WIDTH)) &&
                                   (NUM_NEURONS < int'(MAX_WORDS));

    ser_state_t            state_r, state_n;
    logic [CNT_WIDTH-1:0]  index_r, index_n;
    logic [BUF_BITS-1:0]   buffer_r, buffer_n;
    logic [DATA_WIDTH-1:0] out_data_r, out_data_n;
    logic                  out_valid_r, out_valid_n;
    logic                  busy_r, busy_n;
    logic                  frame_done_r, frame_done_n;
    logic                  err_overrun_r, err_overrun_n;
    logic                  err_partial_r, err_partial_n;

    logic                  fire_s, partial_s, last_s, capture_s, overrun_s;
    logic [CNT_WIDTH-1:0]  next_idx_s;
    logic [DATA_WIDTH-1:0] word_s;

    assign fire_s     = &bus.neuron_valid;
    assign partial_s  = (|bus.neuron_valid) & ~fire_s;
    assign last_s     = (index_r == LAST_IDX);
    assign capture_s  = fire_s & ((state_r == IDLE) | last_s);
    assign overrun_s  = fire_s & (state_r == SHIFT) & ~last_s;
    assign next_idx_s = index_r + CNT_WIDTH'(1);

    // Word for the next beat; only consumed while the index is below the last.
    generate
        if (USE_PKG_SLICE) begin : g_pkg_slice
            logic [MAX_WORDS*DEFAULT_DATA_WIDTH-1:0] buf_ext_s;
            assign buf_ext_s = {{(MAX_WORDS*DEFAULT_DATA_WIDTH-BUF_BITS){1'b0}}, buffer_r};
            assign word_s    = get_word(buf_ext_s, 32'(next_idx_s));
        end else begin : g_direct_slice
            assign word_s = buffer_r[int'(next_idx_s)*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Next-state and next-output computation; outputs describe the upcoming cycle.
    always_comb begin
        state_n      = state_r;
        index_n      = index_r;
        buffer_n     = buffer_r;
        out_data_n   = out_data_r;
        out_valid_n  = 1'b0;
        busy_n       = 1'b0;
        frame_done_n = 1'b0;
        if (capture_s) begin
            state_n     = SHIFT;
            index_n     = {CNT_WIDTH{1'b0}};
            buffer_n    = bus.neuron_out;
            out_data_n  = bus.neuron_out[DATA_WIDTH-1:0];
            out_valid_n = 1'b1;
            busy_n      = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_n = IDLE;
                end
                SHIFT: begin
                    if (last_s) begin
                        state_n = IDLE;
                    end else begin
                        index_n      = next_idx_s;
                        out_data_n   = word_s;
                        out_valid_n  = 1'b1;
                        busy_n       = 1'b1;
                        frame_done_n = (next_idx_s == LAST_IDX);
                    end
                end
                default: begin
                    state_n = IDLE;
                    index_n = {CNT_WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Sticky error flags: a new event takes priority over clr_err.
    always_comb begin
        if (overrun_s) begin
            err_overrun_n = 1'b1;
        end else if (clr_err) begin
            err_overrun_n = 1'b0;
        end else begin
            err_overrun_n = err_overrun_r;
        end
        if (partial_s) begin
            err_partial_n = 1'b1;
        end else if (clr_err) begin
            err_partial_n = 1'b0;
        end else begin
            err_partial_n = err_partial_r;
        end
    end

    // State, buffer, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            index_r       <= {CNT_WIDTH{1'b0}};
            buffer_r      <= {BUF_BITS{1'b0}};
            out_data_r    <= {DATA_WIDTH{1'b0}};
            out_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            err_overrun_r <= 1'b0;
            err_partial_r <= 1'b0;
        end else begin
            state_r       <= state_n;
            index_r       <= index_n;
            buffer_r      <= buffer_n;
            out_data_r    <= out_data_n;
            out_valid_r   <= out_valid_n;
            busy_r        <= busy_n;
            frame_done_r  <= frame_done_n;
            err_overrun_r <= err_overrun_n;
            err_partial_r <= err_partial_n;
        end
    end

    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign busy          = busy_r;
    assign frame_done    = frame_done_r;
    assign err_overrun   = err_overrun_r;
    assign err_partial   = err_partial_r;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Scoreboard bench for layer_out_serializer: a frame-level model queues expected
// beats, a negedge monitor pops and compares every presented beat and flag.
module tb_layer_out_serializer;

    localparam int N  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_err = 1'b0;
    logic busy, frame_done, err_overrun, err_partial;

    layer_out_serializer_if #(.NUM_NEURONS(N), .DATA_WIDTH(DW)) bus ();

    layer_out_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .clr_err     (clr_err),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_overrun (err_overrun),
        .err_partial (err_partial)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [DW:0]  expq[$];          // {is_last_beat, word}
    int           pending  = 0;     // beats still to be shown, current cycle included
    bit           exp_ovr  = 1'b0;
    bit           exp_par  = 1'b0;
    bit           last_rst = 1'b0;
    bit           mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one call per clock edge with the inputs sampled there.
    task automatic model(input logic [N-1:0] nv, input logic [N*DW-1:0] no,
                         input logic clr, input logic r);
        bit fire, part, ovr;
        last_rst = r;
        if (r) begin
            expq.delete();
            pending = 0;
            exp_ovr = 1'b0;
            exp_par = 1'b0;
        end else begin
            fire = (nv == {N{1'b1}});
            part = (nv != {N{1'b0}}) && !fire;
            ovr  = fire && (pending > 1);
            if (fire && pending <= 1) begin
                pending = N;
                for (int i = 0; i < N; i++)
                    expq.push_back({(i == N - 1) ? 1'b1 : 1'b0, no[i*DW +: DW]});
            end else if (pending > 0) begin
                pending--;
            end
            exp_ovr = ovr ? 1'b1 : (clr ? 1'b0 : exp_ovr);
            exp_par = part ? 1'b1 : (clr ? 1'b0 : exp_par);
        end
    endtask

    task automatic step(input logic [N-1:0] nv, input logic [N*DW-1:0] no,
                        input logic clr, input logic r);
        @(negedge clk);
        bus.neuron_valid = nv;
        bus.neuron_out   = no;
        clr_err          = clr;
        rst              = r;
        @(posedge clk);
        model(nv, no, clr, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step({N{1'b0}}, {$urandom, $urandom}, 1'b0, 1'b0);
    endtask

    task automatic fire_frame(input logic [N*DW-1:0] no);
        step({N{1'b1}}, no, 1'b0, 1'b0);
    endtask

    // Monitor: outputs are stable half a cycle after the active edge.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (mon_en) begin
            if (last_rst) begin
                check("reset_out_data", 32'(bus.out_data), 32'd0);
            end
            check("out_valid", 32'(bus.out_valid), 32'(pending > 0));
            check("busy", 32'(busy), 32'(pending > 0));
            if (bus.out_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none at %0t", bus.out_data, $time);
                end else begin
                    e = expq.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(e[DW-1:0]));
                    check("frame_done", 32'(frame_done), 32'(e[DW]));
                end
            end else begin
                check("frame_done_idle", 32'(frame_done), 32'd0);
            end
            check("err_overrun", 32'(err_overrun), 32'(exp_ovr));
            check("err_partial", 32'(err_partial), 32'(exp_par));
        end
    end

    initial begin
        bus.neuron_valid = {N{1'b0}};
        bus.neuron_out   = {N*DW{1'b0}};
        step({N{1'b0}}, {N*DW{1'b0}}, 1'b0, 1'b1);
        mon_en = 1'b1;
        idle(2);

        // Basic frame
        fire_frame({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        idle(6);

        // Back-to-back: second fire while the last beat is shown
        fire_frame({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        idle(3);
        fire_frame({16'h0008, 16'h0007, 16'h0006, 16'h0005});
        idle(6);

        // Overrun during beat 1, then clear
        fire_frame({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        idle(1);
        fire_frame({16'h0008, 16'h0007, 16'h0006, 16'h0005});
        idle(5);
        step({N{1'b0}}, {N*DW{1'b0}}, 1'b1, 1'b0);
        idle(2);

        // Partial valid
        step(4'b0101, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 1'b0, 1'b0);
        idle(3);
        step({N{1'b0}}, {N*DW{1'b0}}, 1'b1, 1'b0);

        // Reset while beat 2 is shown, then a fresh frame
        fire_frame({16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD});
        idle(2);
        step({N{1'b0}}, {N*DW{1'b0}}, 1'b0, 1'b1);
        idle(3);
        fire_frame({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        idle(6);

        // Extreme data, bit-exact
        fire_frame({16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000});
        idle(6);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            int unsigned r;
            logic [N-1:0] nv;
            r  = $urandom_range(0, 99);
            nv = (r < 60) ? {N{1'b0}} : (r < 88) ? {N{1'b1}} : N'($urandom);
            step(nv, {$urandom, $urandom}, ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 99) == 0));
        end
        idle(8);

        check("drained", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_out_serializer.md
Name: layer_out_serializer

Overview:
- Sits between two fully connected layers: captures the parallel outputs of all neurons of layer L, which assert outvalid in the same cycle, and streams them one value per cycle as the myinput/myinputValid pair broadcast to every neuron of layer L+1.
- Provides back-to-back frame acceptance, sticky error flags for overrun and partial-valid events, and a busy indicator for the layer controller.

Parameters:
- NUM_NEURONS, 30, number of neurons in the producing layer, and so the number of beats per frame; must be >= 2.
- DATA_WIDTH, 16, width of one neuron output (activation ROM or ReLU output).
- CNT_WIDTH, $clog2(NUM_NEURONS), width of the beat index counter (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- neuron_out  in  NUM_NEURONS*DATA_WIDTH  packed neuron outputs; neuron i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- neuron_valid  in  NUM_NEURONS  per-neuron outvalid
- clr_err  in  1  synchronous clear of the sticky error flags
- out_data  out  DATA_WIDTH  serial data to the next layer's myinput
- out_valid  out  1  to the next layer's myinputValid
- busy  out  1  high while a frame is being streamed
- frame_done  out  1  one-cycle pulse, coincident with the last beat of a frame
- err_overrun  out  1  sticky: a complete frame arrived while busy and was dropped
- err_partial  out  1  sticky: some, but not all, neuron_valid bits were high in a cycle

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - out_data=0, out_valid=0, busy=0, frame_done=0, err_overrun=0, err_partial=0;
  - state=IDLE, index=0, capture buffer=0.
  - Reset mid-frame aborts the frame. No further beats are emitted.
- Frame start: fire = &neuron_valid. partial = (|neuron_valid) & ~fire.
- FSM has two states, IDLE and SHIFT.
  - IDLE with fire: latch all of neuron_out into buffer, index<=0, go to SHIFT.
  - IDLE without fire: hold.
  - SHIFT, each cycle: out_valid=1, out_data=buffer[index], index<=index+1.
  - SHIFT at index==NUM_NEURONS-1: frame_done=1.
    - With fire in the same cycle: recapture the buffer, index<=0, stay in SHIFT (back-to-back, no bubble).
    - Otherwise: go to IDLE.
  - SHIFT with fire at any index other than the last: frame dropped, buffer unchanged, err_overrun<=1.
- Latency: fire sampled at edge k. Beat 0 (neuron 0) is valid in the cycle after edge k. Beat N-1 is valid in the cycle after edge k+N-1. out_valid is high for exactly NUM_NEURONS consecutive cycles per frame.
- Outputs out_data, out_valid and frame_done are registered. out_data holds its last value when out_valid=0; downstream must qualify with out_valid.
- busy = (state==SHIFT), registered alongside out_valid so that busy==out_valid.
- err_partial<=1 on any partial cycle. No capture occurs on a partial cycle.
- Errors are sticky until rst or clr_err.
  - If clr_err coincides with a new error event, the set wins.
- Data is passed bit-exact, with no arithmetic and no sign handling; values are treated as opaque DATA_WIDTH words.
- The index never exceeds NUM_NEURONS-1. Wrap is handled by the FSM, not by counter overflow, so non-power-of-two NUM_NEURONS is legal.

Decomposition:
- Shared package fnn_pkg holds:
  - DATA_WIDTH default (16);
  - typedef enum logic {IDLE, SHIFT} ser_state_t;
  - function get_word(buffer, idx) for packed-vector slicing, reused by the next-layer controller.
- No sub-module: the buffer, counter and FSM form a single always_ff/always_comb pair, roughly 150 lines.

Test Plan:
- Basic frame (NUM_NEURONS=4, DATA_WIDTH=16): neuron_out={16'h0004,16'h0003,16'h0002,16'h0001}, all valid for 1 cycle -> out_valid high 4 cycles, out_data 0001,0002,0003,0004; frame_done on the 4th beat; busy drops after it.
- Back-to-back: second frame {0008,0007,0006,0005} fired in the cycle of beat 3 -> 8 contiguous out_valid cycles 0001..0008, no bubble, no error.
- Overrun: second frame fired during beat 1 -> err_overrun=1, output remains 0001..0004, then idle; clr_err pulse -> err_overrun=0.
- Partial valid: neuron_valid=4'b0101 -> err_partial=1, out_valid stays 0, busy stays 0.
- Reset mid-frame: rst asserted on beat 2 -> next cycle all outputs 0, no further beats; a fresh frame afterwards streams correctly.
- Negative/extreme data: frame {8000,FFFF,7FFF,0000} -> bit-exact 0000,7FFF,FFFF,8000 on out_data.
